// File: rtl/ddr3_axi_tester_pkg.sv
// Shared definitions for the DDR3 AXI traffic tester: FSM encodings, AXI constants,
// LFSR taps and small helpers used by the top level and the pattern generators.
package ddr3_axi_tester_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WADDR = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_RADDR = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Right-shift Galois form of x^32+x^22+x^2+x+1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr3_axi_tester_if.sv
// AXI4 write/read port bundle between the tester (master) and the DDR3 controller (slave).
// Signal suffixes follow the tester's point of view.
interface ddr3_axi_tester_if #(
    parameter int ADDRS = 27,
    parameter int WIDTH = 32,
    parameter int REQID = 4
);
    logic                 awvalid_o;
    logic                 awready_i;
    logic [ADDRS-1:0]     awaddr_o;
    logic [REQID-1:0]     awid_o;
    logic [7:0]           awlen_o;
    logic [1:0]           awburst_o;

    logic                 wvalid_o;
    logic                 wready_i;
    logic                 wlast_o;
    logic [WIDTH/8-1:0]   wstrb_o;
    logic [WIDTH-1:0]     wdata_o;

    logic                 bvalid_i;
    logic                 bready_o;
    logic [1:0]           bresp_i;
    logic [REQID-1:0]     bid_i;

    logic                 arvalid_o;
    logic                 arready_i;
    logic [ADDRS-1:0]     araddr_o;
    logic [REQID-1:0]     arid_o;
    logic [7:0]           arlen_o;
    logic [1:0]           arburst_o;

    logic                 rvalid_i;
    logic                 rready_o;
    logic                 rlast_i;
    logic [1:0]           rresp_i;
    logic [REQID-1:0]     rid_i;
    logic [WIDTH-1:0]     rdata_i;

    modport master (
        output awvalid_o, awaddr_o, awid_o, awlen_o, awburst_o,
        input  awready_i,
        output wvalid_o, wlast_o, wstrb_o, wdata_o,
        input  wready_i,
        input  bvalid_i, bresp_i, bid_i,
        output bready_o,
        output arvalid_o, araddr_o, arid_o, arlen_o, arburst_o,
        input  arready_i,
        input  rvalid_i, rlast_i, rresp_i, rid_i, rdata_i,
        output rready_o
    );

    modport slave (
        input  awvalid_o, awaddr_o, awid_o, awlen_o, awburst_o,
        output awready_i,
        input  wvalid_o, wlast_o, wstrb_o, wdata_o,
        output wready_i,
        output bvalid_i, bresp_i, bid_i,
        input  bready_o,
        input  arvalid_o, araddr_o, arid_o, arlen_o, arburst_o,
        output arready_i,
        output rvalid_i, rlast_i, rresp_i, rid_i, rdata_i,
        input  rready_o
    );

endinterface

// File: rtl/ddr3_axi_tester_lfsr32.sv
// 32-bit Galois LFSR pattern source: load restarts from SEED, step advances one beat.
module tester_lfsr32
    import ddr3_axi_tester_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] state_o
);
    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ddr3_axi_tester.sv
// Writes an LFSR pattern over a region in INCR bursts, reads it back and counts mismatches.
// Define DDR3_TESTER_ERRLOG_EN to capture the address/data of the first failure.
module ddr3_axi_tester
    import ddr3_axi_tester_pkg::*;
#(
    parameter int                ADDRS      = 27,
    parameter int                WIDTH      = 32,
    parameter int                REQID      = 4,
    parameter int                BURST_LEN  = 8,
    parameter int                NUM_BURSTS = 16,
    parameter logic [ADDRS-1:0]  BASE_ADDR  = '0,
    parameter logic [31:0]       SEED       = 32'h1,
    parameter logic [REQID-1:0]  TEST_ID    = REQID'(4'h5)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       errors_o,
    output logic [ADDRS-1:0]  err_addr_o,
    output logic [WIDTH-1:0]  err_data_o,
    ddr3_axi_tester_if.master axi
);
    localparam int               BEAT_BYTES  = WIDTH / 8;
    localparam logic [ADDRS-1:0] BURST_BYTES = ADDRS'(BURST_LEN * BEAT_BYTES);
    localparam int               BW          = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BW-1:0]    LAST_BURST  = BW'(NUM_BURSTS - 1);
    localparam logic [7:0]       LAST_BEAT   = 8'(BURST_LEN - 1);

    logic [2:0]       state_q, state_d;
    logic [ADDRS-1:0] addr_q, addr_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [7:0]       beat_q, beat_d;
    logic [15:0]      errors_q, errors_d;
    logic             done_q, done_d;

    logic [31:0] wr_pat, rd_pat;
    logic        start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        last_beat, last_burst, b_err, r_err;

    assign start_ok   = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign aw_hs      = (state_q == ST_WADDR) && axi.awready_i;
    assign w_hs       = (state_q == ST_WDATA) && axi.wready_i;
    assign b_hs       = (state_q == ST_WRESP) && axi.bvalid_i;
    assign ar_hs      = (state_q == ST_RADDR) && axi.arready_i;
    assign r_hs       = (state_q == ST_RDATA) && axi.rvalid_i;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);

    assign b_err = b_hs && (axi.bresp_i != RESP_OKAY || axi.bid_i != TEST_ID);
    // rlast is only judged here; the beat counter alone decides when a burst ends.
    assign r_err = r_hs && (axi.rdata_i != WIDTH'(rd_pat) || axi.rresp_i != RESP_OKAY ||
                            axi.rid_i != TEST_ID || axi.rlast_i != last_beat);

    tester_lfsr32 #(.SEED(SEED)) u_wr_lfsr (
        .clock  (clock),
        .reset  (reset),
        .load_i (start_ok),
        .step_i (w_hs),
        .state_o(wr_pat)
    );

    tester_lfsr32 #(.SEED(SEED)) u_rd_lfsr (
        .clock  (clock),
        .reset  (reset),
        .load_i (start_ok),
        .step_i (r_hs),
        .state_o(rd_pat)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        errors_d = (b_err || r_err) ? sat_inc(errors_q) : errors_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_WADDR;
                    addr_d   = BASE_ADDR;
                    burst_d  = '0;
                    beat_d   = '0;
                    errors_d = '0;
                    done_d   = 1'b0;
                end
            end
            ST_WADDR: if (aw_hs) state_d = ST_WDATA;
            ST_WDATA: begin
                if (w_hs) begin
                    beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
                    if (last_beat) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    burst_d = last_burst ? '0 : burst_q + BW'(1);
                    addr_d  = last_burst ? BASE_ADDR : addr_q + BURST_BYTES;
                    state_d = last_burst ? ST_RADDR : ST_WADDR;
                end
            end
            ST_RADDR: if (ar_hs) state_d = ST_RDATA;
            ST_RDATA: begin
                if (r_hs) begin
                    beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
                    if (last_beat) begin
                        burst_d = last_burst ? '0 : burst_q + BW'(1);
                        addr_d  = last_burst ? BASE_ADDR : addr_q + BURST_BYTES;
                        state_d = last_burst ? ST_DONE : ST_RADDR;
                        done_d  = last_burst;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            burst_q  <= '0;
            beat_q   <= '0;
            errors_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            errors_q <= errors_d;
            done_q   <= done_d;
        end
    end

`ifdef DDR3_TESTER_ERRLOG_EN
    logic             err_seen_q, err_seen_d;
    logic [ADDRS-1:0] err_addr_q, err_addr_d;
    logic [WIDTH-1:0] err_data_q, err_data_d;

    always_comb begin
        err_seen_d = err_seen_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        if (start_ok) begin
            err_seen_d = 1'b0;
            err_addr_d = '0;
            err_data_d = '0;
        end else if (!err_seen_q && (b_err || r_err)) begin
            // A write-response failure has no beat, so it logs the burst address.
            err_seen_d = 1'b1;
            err_addr_d = r_err ? addr_q + ADDRS'(beat_q) * ADDRS'(BEAT_BYTES) : addr_q;
            err_data_d = r_err ? axi.rdata_i : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            err_seen_q <= err_seen_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_data_o = err_data_q;
`else
    assign err_addr_o = '0;
    assign err_data_o = '0;
`endif

    assign busy_o   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o   = done_q;
    assign pass_o   = done_q && (errors_q == 16'd0);
    assign errors_o = errors_q;

    assign axi.awvalid_o = (state_q == ST_WADDR);
    assign axi.awaddr_o  = addr_q;
    assign axi.awid_o    = TEST_ID;
    assign axi.awlen_o   = LAST_BEAT;
    assign axi.awburst_o = BURST_INCR;
    assign axi.wvalid_o  = (state_q == ST_WDATA);
    assign axi.wlast_o   = (state_q == ST_WDATA) && last_beat;
    assign axi.wstrb_o   = '1;
    assign axi.wdata_o   = WIDTH'(wr_pat);
    assign axi.bready_o  = (state_q == ST_WRESP);
    assign axi.arvalid_o = (state_q == ST_RADDR);
    assign axi.araddr_o  = addr_q;
    assign axi.arid_o    = TEST_ID;
    assign axi.arlen_o   = LAST_BEAT;
    assign axi.arburst_o = BURST_INCR;
    assign axi.rready_o  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_ddr3_axi_tester.sv
// Bench for ddr3_axi_tester: AXI memory model with stalls/fault injection plus a
// one-beat instance; expected data comes from an independent LFSR reference.
`timescale 1ns/1ps
module tb_ddr3_axi_tester;
    localparam int BL = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_i = 1'b0;
    logic start1_i = 1'b0;
    logic busy_o, done_o, pass_o, busy1_o, done1_o, pass1_o;
    logic [15:0] errors_o, errors1_o;
    logic [26:0] err_addr_o, err_addr1_o;
    logic [31:0] err_data_o, err_data1_o;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    ddr3_axi_tester_if #(.ADDRS(27), .WIDTH(32), .REQID(4)) bus ();
    ddr3_axi_tester_if #(.ADDRS(27), .WIDTH(32), .REQID(4)) bus1 ();

    ddr3_axi_tester u_dut (
        .clock(clock), .reset(reset), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .errors_o(errors_o), .err_addr_o(err_addr_o), .err_data_o(err_data_o),
        .axi(bus.master)
    );

    ddr3_axi_tester #(.BURST_LEN(1), .NUM_BURSTS(1)) u_dut1 (
        .clock(clock), .reset(reset), .start_i(start1_i), .busy_o(busy1_o), .done_o(done1_o),
        .pass_o(pass1_o), .errors_o(errors1_o), .err_addr_o(err_addr1_o), .err_data_o(err_data1_o),
        .axi(bus1.master)
    );

    // Reference pattern: one Galois step of x^32+x^22+x^2+x+1 per beat.
    function automatic logic [31:0] ref_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_nth(input int n);
        logic [31:0] s = 32'h1;
        for (int i = 0; i < n; i++) s = ref_next(s);
        return s;
    endfunction

    // Fault/stall knobs, written only by the stimulus block.
    logic        stall = 1'b0;
    logic        corrupt_en = 1'b0;
    int          bad_b_burst = -1;
    int          omit_burst = -1;
    logic        drop_rlast1 = 1'b0;

    // Memory model state and observations.
    logic [31:0] mem [int];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, w_bad, wlast_bad, proto_bad;
    int          w_beat, r_beat, b_idx, r_idx;
    logic [26:0] first_aw, last_ar, w_base, r_base, aw_hold, ar_hold, r_byte;
    logic [31:0] w_exp, w_hold_d;
    logic        w_hold_l, aw_wait, w_wait, ar_wait, w_open, b_pend, r_pend;

    // All handshakes are decided at the falling edge and complete on the next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            bus.awready_i = 0; bus.wready_i = 0; bus.arready_i = 0;
            bus.bvalid_i = 0; bus.bresp_i = 0; bus.bid_i = 0;
            bus.rvalid_i = 0; bus.rlast_i = 0; bus.rresp_i = 0; bus.rid_i = 0; bus.rdata_i = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            w_bad = 0; wlast_bad = 0; proto_bad = 0; w_beat = 0; r_beat = 0; b_idx = 0; r_idx = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; w_open = 0; b_pend = 0; r_pend = 0;
            w_exp = 32'h1; first_aw = '1; last_ar = '1;
        end else begin
            if (start_i && !busy_o) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                w_bad = 0; wlast_bad = 0; proto_bad = 0; w_beat = 0; r_beat = 0;
                b_idx = 0; r_idx = 0; w_exp = 32'h1; first_aw = '1; last_ar = '1;
            end
            bus.bid_i = 4'h5;
            bus.rid_i = 4'h5;
            bus.rresp_i = 2'b00;
            if (b_pend) begin
                bus.bvalid_i = 1;
                bus.bresp_i = (b_idx == bad_b_burst) ? 2'b10 : 2'b00;
                if (bus.bready_o) begin b_pend = 0; b_cnt++; b_idx++; end
            end else begin
                bus.bvalid_i = 0;
                bus.bresp_i = 0;
            end
            if (r_pend) begin
                bus.rvalid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                r_byte = r_base + 27'(r_beat * 4);
                bus.rdata_i = mem[int'(r_byte >> 2)] ^ ((corrupt_en && r_byte == 27'h44) ? 32'h1 : 32'h0);
                bus.rlast_i = (r_beat == BL - 1) && (r_idx != omit_burst);
                if (bus.rvalid_i && bus.rready_o) begin
                    r_cnt++; r_beat++;
                    if (r_beat == BL) begin r_beat = 0; r_pend = 0; r_idx++; end
                end
            end else begin
                bus.rvalid_i = 0;
                bus.rlast_i = 0;
            end
            if (aw_wait && (!bus.awvalid_o || bus.awaddr_o != aw_hold)) proto_bad++;
            bus.awready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_wait = 0;
            if (bus.awvalid_o) begin
                if (w_open || b_pend || r_pend) proto_bad++;
                if (bus.awready_i) begin
                    if (aw_cnt == 0) first_aw = bus.awaddr_o;
                    aw_cnt++; w_base = bus.awaddr_o; w_open = 1; w_beat = 0;
                end else begin
                    aw_wait = 1; aw_hold = bus.awaddr_o;
                end
            end
            if (w_wait && (!bus.wvalid_o || bus.wdata_o != w_hold_d || bus.wlast_o != w_hold_l)) proto_bad++;
            bus.wready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_wait = 0;
            if (bus.wvalid_o) begin
                if (!w_open) proto_bad++;
                if (bus.wready_i) begin
                    w_cnt++;
                    if (bus.wdata_o != w_exp) w_bad++;
                    if (bus.wlast_o != (w_beat == BL - 1)) wlast_bad++;
                    mem[int'(w_base >> 2) + w_beat] = bus.wdata_o;
                    w_exp = ref_next(w_exp);
                    w_beat++;
                    if (w_beat == BL) begin w_beat = 0; w_open = 0; b_pend = 1; end
                end else begin
                    w_wait = 1; w_hold_d = bus.wdata_o; w_hold_l = bus.wlast_o;
                end
            end
            if (ar_wait && (!bus.arvalid_o || bus.araddr_o != ar_hold)) proto_bad++;
            bus.arready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ar_wait = 0;
            if (bus.arvalid_o) begin
                if (r_pend || b_pend || w_open) proto_bad++;
                if (bus.arready_i) begin
                    ar_cnt++; last_ar = bus.araddr_o; r_base = bus.araddr_o; r_pend = 1; r_beat = 0;
                end else begin
                    ar_wait = 1; ar_hold = bus.araddr_o;
                end
            end
        end
    end

    // Always-ready responder for the single-beat instance.
    int          w1_cnt, w1_last_bad;
    logic [31:0] w1_data;
    logic        b1_pend, r1_pend;

    always @(negedge clock) begin
        if (reset) begin
            bus1.awready_i = 0; bus1.wready_i = 0; bus1.arready_i = 0;
            bus1.bvalid_i = 0; bus1.bresp_i = 0; bus1.bid_i = 0;
            bus1.rvalid_i = 0; bus1.rlast_i = 0; bus1.rresp_i = 0; bus1.rid_i = 0; bus1.rdata_i = 0;
            w1_cnt = 0; w1_last_bad = 0; w1_data = 0; b1_pend = 0; r1_pend = 0;
        end else begin
            bus1.awready_i = 1; bus1.wready_i = 1; bus1.arready_i = 1;
            bus1.bid_i = 4'h5; bus1.rid_i = 4'h5; bus1.bresp_i = 0; bus1.rresp_i = 0;
            if (start1_i && !busy1_o) begin w1_cnt = 0; w1_last_bad = 0; end
            bus1.bvalid_i = b1_pend;
            if (b1_pend && bus1.bready_o) b1_pend = 0;
            bus1.rvalid_i = r1_pend;
            bus1.rdata_i = w1_data;
            bus1.rlast_i = r1_pend && !drop_rlast1;
            if (r1_pend && bus1.rready_o) r1_pend = 0;
            if (bus1.wvalid_o) begin
                w1_data = bus1.wdata_o; w1_cnt++;
                if (!bus1.wlast_o) w1_last_bad++;
                b1_pend = 1;
            end
            if (bus1.arvalid_o) r1_pend = 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pulse(input bit inst1);
        @(posedge clock); #1;
        if (inst1) start1_i = 1'b1; else start_i = 1'b1;
        @(posedge clock); #1;
        start_i = 1'b0;
        start1_i = 1'b0;
    endtask

    task automatic wait_done(input bit inst1, input string tag);
        int n = 0;
        while (!(inst1 ? done1_o : done_o) && n < 4000) begin @(posedge clock); #1; n++; end
        chk(tag, 64'(inst1 ? done1_o : done_o), 64'd1);
    endtask

    task automatic chk_traffic(input string tag);
        chk({tag, "_aw"}, 64'(aw_cnt), 64'd16);
        chk({tag, "_w"}, 64'(w_cnt), 64'd128);
        chk({tag, "_b"}, 64'(b_cnt), 64'd16);
        chk({tag, "_ar"}, 64'(ar_cnt), 64'd16);
        chk({tag, "_r"}, 64'(r_cnt), 64'd128);
        chk({tag, "_wdata"}, 64'(w_bad), 64'd0);
        chk({tag, "_wlast"}, 64'(wlast_bad), 64'd0);
        chk({tag, "_proto"}, 64'(proto_bad), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ctrl", {bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.arvalid_o, bus.rready_o,
                         busy_o, done_o, pass_o}, 64'd0);
        chk("rst_errors", 64'(errors_o), 64'd0);
        chk("rst_errlog", {err_addr_o, err_data_o}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("const_len", {bus.awlen_o, bus.arlen_o}, 64'h0707);
        chk("const_burst_id", {bus.awburst_o, bus.arburst_o, bus.awid_o, bus.arid_o}, 64'h555);
        chk("const_wstrb", 64'(bus.wstrb_o), 64'hF);
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Clean run, with a start pulse issued mid-run that must be ignored.
        pulse(0);
        chk("aw_latency", 64'(bus.awvalid_o), 64'd1);
        chk("busy_run", 64'(busy_o), 64'd1);
        n = 0;
        while (aw_cnt < 5 && n < 1000) begin @(posedge clock); #1; n++; end
        chk("reach_burst5", 64'(aw_cnt >= 5), 64'd1);
        pulse(0);
        wait_done(0, "clean_done");
        chk_traffic("clean");
        chk("clean_pass", {pass_o, errors_o}, {1'b1, 16'd0});
        chk("clean_first_aw", 64'(first_aw), 64'h0);
        chk("clean_last_ar", 64'(last_ar), 64'h1E0);
        chk("done_held_busy", {done_o, busy_o}, 64'b10);

        // One flipped bit in the beat at byte 0x44.
        corrupt_en = 1'b1;
        pulse(0);
        chk("start_clears", {done_o, pass_o, errors_o}, 64'd0);
        wait_done(0, "corrupt_done");
        chk("corrupt_errors", 64'(errors_o), 64'd1);
        chk("corrupt_pass", 64'(pass_o), 64'd0);
`ifdef DDR3_TESTER_ERRLOG_EN
        chk("corrupt_err_addr", 64'(err_addr_o), 64'h44);
        chk("corrupt_err_data", 64'(err_data_o), 64'(ref_nth(17) ^ 32'h1));
`else
        chk("corrupt_errlog_off", {err_addr_o, err_data_o}, 64'd0);
`endif
        corrupt_en = 1'b0;

        // Random stalls on every slave-driven handshake.
        stall = 1'b1;
        pulse(0);
        wait_done(0, "stall_done");
        chk_traffic("stall");
        chk("stall_pass", {pass_o, errors_o}, {1'b1, 16'd0});
        stall = 1'b0;

        // SLVERR on burst 3 write response, missing rlast on burst 5.
        bad_b_burst = 3;
        omit_burst = 5;
        pulse(0);
        wait_done(0, "resp_done");
        chk("resp_errors", 64'(errors_o), 64'd2);
        chk("resp_pass", 64'(pass_o), 64'd0);
        chk("resp_b_cnt", 64'(b_cnt), 64'd16);
        chk("resp_r_cnt", 64'(r_cnt), 64'd128);
`ifdef DDR3_TESTER_ERRLOG_EN
        chk("resp_err_log", {err_addr_o, err_data_o}, {27'h60, 32'h0});
`endif
        bad_b_burst = -1;
        omit_burst = -1;

        // Asynchronous reset during the write data phase of burst 2.
        pulse(0);
        n = 0;
        while (!(aw_cnt == 3 && bus.wvalid_o) && n < 1000) begin @(posedge clock); #1; n++; end
        chk("reach_wdata2", 64'(aw_cnt == 3 && bus.wvalid_o), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_ctrl", {bus.awvalid_o, bus.wvalid_o, bus.wlast_o, bus.bready_o, bus.arvalid_o,
                           bus.rready_o, busy_o, done_o, pass_o}, 64'd0);
        chk("abort_errors", 64'(errors_o), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        pulse(0);
        wait_done(0, "restart_done");
        chk_traffic("restart");
        chk("restart_pass", {pass_o, errors_o}, {1'b1, 16'd0});

        // Single-beat, single-burst configuration.
        pulse(1);
        wait_done(1, "bl1_done");
        chk("bl1_pass", {pass1_o, errors1_o}, {1'b1, 16'd0});
        chk("bl1_wcnt", 64'(w1_cnt), 64'd1);
        chk("bl1_wlast", 64'(w1_last_bad), 64'd0);
        chk("bl1_wdata", 64'(w1_data), 64'(ref_nth(0)));
        drop_rlast1 = 1'b1;
        pulse(1);
        wait_done(1, "bl1_norlast_done");
        chk("bl1_norlast_errors", {pass1_o, errors1_o}, {1'b0, 16'd1});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
